// File: rtl/clz_radix2_divider_pkg.sv
// Shared definitions for the CLZ-assisted radix-2 unsigned divider.
// The divider's own state encoding stays local to the divider module.
package clz_radix2_divider_pkg;

    localparam int unsigned DIV_DEFAULT_WIDTH = 32;

    // How a newly started operation is handled.
    typedef enum logic [1:0] {
        DEC_DIV_ZERO  = 2'd0,
        DEC_TOO_SMALL = 2'd1,
        DEC_ITERATE   = 2'd2
    } div_decode_e;

endpackage

// File: rtl/clz_radix2_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
// Leading-zero counts from the requester let it skip iterations that can only produce zero bits.
module clz_radix2_divider
    import clz_radix2_divider_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [DATA_WIDTH-1:0]         dividend,
    input  logic [$clog2(DATA_WIDTH)-1:0] dividend_CLZ,
    input  logic [DATA_WIDTH-1:0]         divisor,
    input  logic [$clog2(DATA_WIDTH)-1:0] divisor_CLZ,
    input  logic                          divisor_is_zero,
    output logic [DATA_WIDTH-1:0]         quotient,
    output logic [DATA_WIDTH-1:0]         remainder,
    output logic                          done
);

    localparam int CW   = $clog2(DATA_WIDTH);
    localparam int CNTW = CW + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   quotient_q, quotient_d;
    logic [DATA_WIDTH-1:0]   remainder_q, remainder_d;
    logic [DATA_WIDTH-1:0]   shdiv_q, shdiv_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic                    done_q, done_d;
    div_decode_e             decode_s;
    logic [CW-1:0]           shift_s;

    // Classify a new request and compute how far the divisor is pre-aligned.
    always_comb begin
        shift_s = divisor_CLZ - dividend_CLZ;
        if (divisor_is_zero) begin
            decode_s = DEC_DIV_ZERO;
        end else if (divisor_CLZ < dividend_CLZ) begin
            decode_s = DEC_TOO_SMALL;
        end else begin
            decode_s = DEC_ITERATE;
        end
    end

    // Next-state logic: start always wins, even over a running operation.
    always_comb begin
        state_d     = state_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        shdiv_d     = shdiv_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        if (start) begin
            case (decode_s)
                DEC_DIV_ZERO: begin
                    quotient_d  = {DATA_WIDTH{1'b1}};
                    remainder_d = dividend;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
                DEC_TOO_SMALL: begin
                    quotient_d  = {DATA_WIDTH{1'b0}};
                    remainder_d = dividend;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
                DEC_ITERATE: begin
                    quotient_d  = {DATA_WIDTH{1'b0}};
                    remainder_d = dividend;
                    shdiv_d     = divisor << shift_s;
                    cnt_d       = {1'b0, shift_s} + {{CW{1'b0}}, 1'b1};
                    state_d     = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            case (state_q)
                ST_RUN: begin
                    // The alignment guarantees remainder < 2*shdiv, so one subtract per bit suffices.
                    if (remainder_q >= shdiv_q) begin
                        remainder_d = remainder_q - shdiv_q;
                        quotient_d  = {quotient_q[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        quotient_d  = {quotient_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    shdiv_d = shdiv_q >> 1;
                    cnt_d   = cnt_q - {{CW{1'b0}}, 1'b1};
                    if (cnt_q == {{CW{1'b0}}, 1'b1}) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            quotient_q  <= {DATA_WIDTH{1'b0}};
            remainder_q <= {DATA_WIDTH{1'b0}};
            shdiv_q     <= {DATA_WIDTH{1'b0}};
            cnt_q       <= {CNTW{1'b0}};
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            shdiv_q     <= shdiv_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign done      = done_q;

endmodule

// File: doc/clz_radix2_divider.md
# clz_radix2_divider

Iterative unsigned divider that implements the `divider` modport of `unsigned_division_interface`. It sits under the divide execution unit, which computes leading-zero counts and issues a one-cycle `start`. The divider retires one quotient bit per cycle. It uses the CLZ inputs to skip leading iterations that cannot produce a 1.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; must be a power of two ≥ 4.

Ports. Clock and reset come first. There is one clock; reset is asynchronous and active-low.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; latches operands.
- dividend  input  DATA_WIDTH  numerator.
- dividend_CLZ  input  $clog2(DATA_WIDTH)  leading zeros of dividend; may be ≤ the true count (zero dividend supplies DATA_WIDTH-1).
- divisor  input  DATA_WIDTH  denominator.
- divisor_CLZ  input  $clog2(DATA_WIDTH)  exact leading zeros of divisor; ignored when divisor is zero.
- divisor_is_zero  input  1  divisor equals zero.
- quotient  output  DATA_WIDTH  result; registered.
- remainder  output  DATA_WIDTH  result; registered.
- done  output  1  single-cycle pulse; quotient/remainder valid.

## Operation
States: IDLE, RUN.

On `start` (any state), the divider decodes the operands as follows:
- If divisor_is_zero: quotient ← all ones, remainder ← dividend, done next cycle, stay/go IDLE.
- Else if divisor_CLZ < dividend_CLZ, the divisor is larger than the dividend: quotient ← 0, remainder ← dividend, done next cycle, IDLE.
- Otherwise:
  - d = divisor_CLZ − dividend_CLZ.
  - Shifted divisor ← divisor << d; this cannot overflow, since d ≤ divisor_CLZ.
  - Working remainder ← dividend; quotient ← 0.
  - Counter ← d+1, width $clog2(DATA_WIDTH)+1.
  - Go RUN.

Each RUN cycle:
- If remainder ≥ shifted divisor: remainder −= shifted divisor and quotient ← {quotient[W-2:0],1}. Otherwise quotient ← {quotient[W-2:0],0}.
- Shifted divisor >>= 1; counter −= 1.
- When the counter is 1 during this iteration, assert done on the next edge and go IDLE.

All comparisons and subtraction are unsigned at DATA_WIDTH bits; no carry out is possible.

quotient/remainder hold their values after done until the next `start`. They are internal working registers during RUN, and their values there are don't-care to the requester.

`start` during RUN aborts the current operation without a done and restarts with the new operands.

## Timing
- Reset: quotient = 0, remainder = 0, done = 0, state IDLE. Reset asserted mid-operation discards the operation; no done follows reset.
- `start` sampled in cycle 0:
  - Early-exit cases (divisor zero, or divisor larger) assert done in cycle 1.
  - The normal case performs its iterations in cycles 1..N, where N = d+1 ∈ [1, DATA_WIDTH], and asserts done in cycle N+1.
- Worst case (DATA_WIDTH=32, d=31) is done at cycle 33.
- done is high for exactly one cycle per completed operation.
- A `start` in the same cycle as done is accepted. The done pulse still occurs, and the new operation begins.
- No backpressure: the requester must capture the results while done is high, or before its next `start`.

## Structure
- The state enum (IDLE/RUN) is local to the module. No additions to cva5_types or cva5_config.
- Single module with no sub-modules. CLZ computation stays with the requester.

## Test plan
- 100/7 at W=32, CLZ 25/29, N=5 → done in cycle 6, quotient=14, remainder=2.
- divisor_is_zero, dividend=0x1234 → done in cycle 1, quotient=0xFFFFFFFF, remainder=0x1234.
- 5/9, CLZ 29/28 → done in cycle 1, quotient=0, remainder=5.
- 0xFFFFFFFF/1, CLZ 0/31 → done in cycle 33, quotient=0xFFFFFFFF, remainder=0.
- Restart mid-operation:
  - Stimulus: start 100/7 at cycle 0, then start 50/5 (CLZ 26/29) at cycle 3.
  - Required response: a single done at cycle 8, quotient=10, remainder=0.
- Reset mid-operation:
  - Stimulus: start 100/7, rst_n low during cycle 3.
  - Required response: done stays 0 and the outputs are 0. A subsequent 100/7 yields done 6 cycles after its start, with 14/2.
- Randomized reference-model sweep, including dividend=0 with CLZ=31: all results match / and %.
